// File: rtl/fuser_stream.sv
// rtl/fuser_stream.sv - streaming bitwise-majority bundler of NUM_INPUTS hypervectors per group
// Optional feature macro: FUSER_STREAM_FLUSH_EN (adds the flush input for early group close).
module fuser_stream #(
  parameter int HV_DIMENSION = 2000,
  parameter int NUM_INPUTS   = 3,
  parameter int COUNT_WIDTH  = $clog2(NUM_INPUTS + 1),
  parameter int TIE_BREAK    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef FUSER_STREAM_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout,
  output logic [COUNT_WIDTH-1:0]  hvout_count
);

  localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(NUM_INPUTS - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_ONE  = COUNT_WIDTH'(1);

  // Group progress and per-bit running sums; acc is only meaningful while count > 0.
  logic [COUNT_WIDTH-1:0]              r_count;
  logic [HV_DIMENSION*COUNT_WIDTH-1:0] r_acc;
  logic [HV_DIMENSION-1:0]             r_first;
  logic                                r_hvout_valid;
  logic [HV_DIMENSION-1:0]             r_hvout;
  logic [COUNT_WIDTH-1:0]              r_hvout_count;

  logic                                w_hvin_ready;
  logic                                w_in_fire;
  logic                                w_out_fire;
  logic                                w_last;
  logic                                w_flush_close;
  logic                                w_close;
  logic [COUNT_WIDTH-1:0]              w_n;
  logic [HV_DIMENSION*COUNT_WIDTH-1:0] w_sum_flat;
  logic [HV_DIMENSION-1:0]             w_maj;

  // The block accepts a vector whenever the output slot is empty or is draining this cycle.
  assign w_hvin_ready = !r_hvout_valid | hvout_ready;
  assign w_in_fire    = hvin_valid & w_hvin_ready;
  assign w_out_fire   = r_hvout_valid & hvout_ready;
  assign w_last       = w_in_fire & (r_count == LP_LAST);

`ifdef FUSER_STREAM_FLUSH_EN
  // Early close needs a partial group and the output slot free to take the result.
  assign w_flush_close = flush & w_hvin_ready & (r_count != '0);
`else
  assign w_flush_close = 1'b0;
`endif

  assign w_close = w_last | w_flush_close;

  // Group size at close: the vectors already held plus the one firing now.
  // For a normal last-of-group close this equals NUM_INPUTS.
  assign w_n = r_count + COUNT_WIDTH'(w_in_fire);

  for (genvar gi = 0; gi < HV_DIMENSION; gi++) begin : g_bit
    logic [COUNT_WIDTH-1:0] w_base;
    logic [COUNT_WIDTH-1:0] w_sum;
    logic [COUNT_WIDTH:0]   w_twice;
    logic [COUNT_WIDTH:0]   w_n_ext;
    logic                   w_first_bit;
    logic                   w_tie_bit;

    // A fresh group starts from zero, so stale accumulator contents never leak across groups.
    assign w_base      = (r_count == '0) ? '0 : r_acc[gi*COUNT_WIDTH +: COUNT_WIDTH];
    assign w_sum       = w_base + COUNT_WIDTH'(w_in_fire & hvin[gi]);
    assign w_twice     = {w_sum, 1'b0};
    assign w_n_ext     = {1'b0, w_n};
    // When the group is a single vector the first input is the one arriving now.
    assign w_first_bit = (r_count == '0) ? hvin[gi] : r_first[gi];
    assign w_tie_bit   = (TIE_BREAK == 2) ? w_first_bit : (TIE_BREAK == 1);

    assign w_maj[gi] = (w_twice > w_n_ext) ? 1'b1 :
                       (w_twice < w_n_ext) ? 1'b0 : w_tie_bit;

    assign w_sum_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = w_sum;
  end

  // Group counter: advances per accepted vector, returns to zero when the group closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_close) begin
      r_count <= '0;
    end else if (w_in_fire) begin
      r_count <= r_count + LP_ONE;
    end
  end

  // Per-bit accumulators take the running sum on every accepted non-closing vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (w_in_fire && !w_close) begin
      r_acc <= w_sum_flat;
    end
  end

  // First vector of each group, kept for the first-input tie rule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first <= '0;
    end else if (w_in_fire && (r_count == '0)) begin
      r_first <= hvin;
    end
  end

  // Output slot: loads on close (even while draining), clears on drain, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hvout_valid <= 1'b0;
      r_hvout       <= '0;
      r_hvout_count <= '0;
    end else if (w_close) begin
      r_hvout_valid <= 1'b1;
      r_hvout       <= w_maj;
      r_hvout_count <= w_n;
    end else if (w_out_fire) begin
      r_hvout_valid <= 1'b0;
    end
  end

  assign hvin_ready  = w_hvin_ready;
  assign hvout_valid = r_hvout_valid;
  assign hvout       = r_hvout;
  assign hvout_count = r_hvout_count;

endmodule

// File: tb/tb_fuser_stream.sv
// tb/tb_fuser_stream.sv - directed self-checking bench for fuser_stream
module tb_fuser_stream;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_valid;
  logic [7:0] a_data;
  logic       a_oready;
  logic       a_iready;
  logic       a_ovalid;
  logic [7:0] a_out;
  logic [1:0] a_cnt;
`ifdef FUSER_STREAM_FLUSH_EN
  logic       a_flush;
  logic       b_flush;
`endif

  logic       b_valid;
  logic [7:0] b_data;
  logic       b_iready [3];
  logic       b_ovalid [3];
  logic [7:0] b_out    [3];
  logic [1:0] b_cnt    [3];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  fuser_stream #(.HV_DIMENSION(8), .NUM_INPUTS(3), .TIE_BREAK(0)) u_dut3 (
    .clk(clk), .rst(rst),
`ifdef FUSER_STREAM_FLUSH_EN
    .flush(a_flush),
`endif
    .hvin_valid(a_valid), .hvin_ready(a_iready), .hvin(a_data),
    .hvout_valid(a_ovalid), .hvout_ready(a_oready), .hvout(a_out), .hvout_count(a_cnt)
  );

  for (genvar t = 0; t < 3; t++) begin : g_tie
    fuser_stream #(.HV_DIMENSION(8), .NUM_INPUTS(2), .TIE_BREAK(t)) u_dut2 (
      .clk(clk), .rst(rst),
`ifdef FUSER_STREAM_FLUSH_EN
      .flush(b_flush),
`endif
      .hvin_valid(b_valid), .hvin_ready(b_iready[t]), .hvin(b_data),
      .hvout_valid(b_ovalid[t]), .hvout_ready(1'b1), .hvout(b_out[t]), .hvout_count(b_cnt[t])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] v9   [9];
  logic [7:0] res3 [3];
  logic [7:0] tie_exp [3];

  initial begin
    v9   = '{8'hFF, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h33, 8'h55, 8'hAA, 8'h5A};
    res3 = '{8'hFF, 8'h33, 8'h5A};
    tie_exp = '{8'h30, 8'hFC, 8'hF0};

    rst = 1'b0; a_valid = 1'b0; a_data = '0; a_oready = 1'b0;
    b_valid = 1'b0; b_data = '0;
`ifdef FUSER_STREAM_FLUSH_EN
    a_flush = 1'b0; b_flush = 1'b0;
`endif
    #2;
    check("rst_valid", 32'(a_ovalid), 32'd0);
    check("rst_out",   32'(a_out),    32'd0);
    check("rst_cnt",   32'(a_cnt),    32'd0);
    check("rst_ready", 32'(a_iready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic group of three
    a_valid = 1'b1; a_data = 8'hCA;
    @(negedge clk);
    check("g1_valid_after1", 32'(a_ovalid), 32'd0);
    a_data = 8'hA6;
    @(negedge clk);
    check("g1_valid_after2", 32'(a_ovalid), 32'd0);
    a_data = 8'h93;
    @(negedge clk);
    check("g1_valid", 32'(a_ovalid), 32'd1);
    check("g1_out",   32'(a_out),    32'h82);
    check("g1_cnt",   32'(a_cnt),    32'd3);
    a_valid = 1'b0;

    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(a_iready), 32'd0);
      check("bp_valid", 32'(a_ovalid), 32'd1);
      check("bp_out",   32'(a_out),    32'h82);
    end
    a_oready = 1'b1;
    #1;
    check("bp_release_ready", 32'(a_iready), 32'd1);
    @(negedge clk);
    check("bp_drained", 32'(a_ovalid), 32'd0);

    // Back-to-back stream of nine vectors
    for (int k = 0; k < 9; k++) begin
      a_valid = 1'b1; a_data = v9[k];
      @(negedge clk);
      check("b2b_ready", 32'(a_iready), 32'd1);
      check("b2b_valid", 32'(a_ovalid), ((k % 3) == 2) ? 32'd1 : 32'd0);
      if ((k % 3) == 2) begin
        check("b2b_out", 32'(a_out), 32'(res3[k / 3]));
        check("b2b_cnt", 32'(a_cnt), 32'd3);
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("b2b_tail_valid", 32'(a_ovalid), 32'd0);

    // Mid-group asynchronous reset discards the partial group
    a_valid = 1'b1; a_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(a_ovalid), 32'd0);
    check("arst_out",   32'(a_out),    32'd0);
    check("arst_cnt",   32'(a_cnt),    32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    a_data = 8'h00;
    @(negedge clk);
    a_valid = 1'b0;
    check("post_rst_valid", 32'(a_ovalid), 32'd1);
    check("post_rst_out",   32'(a_out),    32'hFF);

    // Tie-break variants with two inputs
    b_valid = 1'b1; b_data = 8'hF0;
    @(negedge clk);
    b_data = 8'h3C;
    @(negedge clk);
    b_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check("tie_valid", 32'(b_ovalid[t]), 32'd1);
      check("tie_out",   32'(b_out[t]),    32'(tie_exp[t]));
      check("tie_cnt",   32'(b_cnt[t]),    32'd2);
    end

`ifdef FUSER_STREAM_FLUSH_EN
    // Early close of a two-vector group
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hFF;
    @(negedge clk);
    a_data = 8'h0F;
    @(negedge clk);
    a_valid = 1'b0;
    check("flush_pre_valid", 32'(a_ovalid), 32'd0);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    check("flush_valid", 32'(a_ovalid), 32'd1);
    check("flush_out",   32'(a_out),    32'h0F);
    check("flush_cnt",   32'(a_cnt),    32'd2);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
